// File: rtl/seq_divider.sv
// seq_divider: unsigned 4-bit restoring divider, one trial subtraction per clock.
// A start/done handshake issues one division at a time; results are registered
// and hold until the next division finishes (div_by_zero clears when a new one starts).
module seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFin
  } state_e;

  state_e     state_q, state_d;

  // Working registers: a_q shifts the dividend out and quotient bits in,
  // r_q holds the partial remainder, d_q the latched divisor.
  logic [3:0] a_q, a_d;
  logic [4:0] r_q, r_d;
  logic [3:0] d_q, d_d;
  logic [1:0] cnt_q, cnt_d;

  // Visible result registers.
  logic [3:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;

  // Trial subtraction done as A + ~B + 1, matching the lab add/sub datapath.
  // trial[4] set means the subtraction borrowed (shifted < divisor).
  logic [4:0] shifted;
  logic [4:0] trial;

  assign shifted = {r_q[3:0], a_q[3]};
  assign trial   = shifted + ~{1'b0, d_q} + 5'd1;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= 4'd0;
      r_q     <= 5'd0;
      d_q     <= 4'd0;
      cnt_q   <= 2'd0;
      quot_q  <= 4'd0;
      rem_q   <= 4'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic: accept in idle, iterate four times, then one-cycle finish.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor != 4'd0) begin
            a_d     = dividend;
            d_d     = divisor;
            r_d     = 5'd0;
            cnt_d   = 2'd0;
            dbz_d   = 1'b0;
            state_d = StCalc;
          end else begin
            // Divide by zero resolves immediately with all-ones quotient.
            quot_d  = 4'hF;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = StFin;
          end
        end
      end

      StCalc: begin
        if (!trial[4]) begin
          r_d = trial;
          a_d = {a_q[2:0], 1'b1};
        end else begin
          r_d = shifted;
          a_d = {a_q[2:0], 1'b0};
        end
        cnt_d = cnt_q + 2'd1;
        // Last iteration publishes the freshly computed values.
        if (cnt_q == 2'd3) begin
          quot_d  = a_d;
          rem_d   = r_d[3:0];
          state_d = StFin;
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs decode the registered state only.
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StFin);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset, boundary cases, divide by zero,
// start while busy, reset mid-division, and an exhaustive back-to-back sweep.
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Last result the bench expects to be visible on the outputs.
  logic [3:0] prev_q = 4'd0;
  logic [3:0] prev_r = 4'd0;

  seq_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one division and follow it to done. inject_at > 0 pulses a 6/2
  // request while busy after that many cycles; chk_hold checks that results
  // stay at their previous values during the calculation.
  task automatic run_div(input logic [3:0] dd, input logic [3:0] dv,
                         input int inject_at, input logic chk_hold);
    logic [3:0] eq;
    logic [3:0] er;
    logic       ez;
    int         lat;
    eq = (dv == 4'd0) ? 4'hF : dd / dv;
    er = (dv == 4'd0) ? dd : dd % dv;
    ez = (dv == 4'd0);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_accept", busy, 1);
    lat = 1;
    while (!done && lat < 20) begin
      check("busy_calc", busy, 1);
      if (chk_hold) begin
        check("hold_q", quotient, prev_q);
        check("hold_r", remainder, prev_r);
        check("hold_dbz", div_by_zero, 0);
      end
      if (lat == inject_at) begin
        dividend = 4'd6;
        divisor  = 4'd2;
        start    = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    check("latency", lat, (dv == 4'd0) ? 1 : 5);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, ez);
    check("busy_fin", busy, 1);
    prev_q = eq;
    prev_r = er;
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    // Basic case and boundaries.
    run_div(4'd13, 4'd3, 0, 1'b1);
    run_div(4'd15, 4'd1, 0, 1'b1);
    run_div(4'd0, 4'd7, 0, 1'b1);
    run_div(4'd5, 4'd9, 0, 1'b1);
    run_div(4'd15, 4'd15, 0, 1'b1);

    // Divide by zero, then a normal division clears the flag.
    run_div(4'd9, 4'd0, 0, 1'b0);
    run_div(4'd8, 4'd2, 0, 1'b0);
    check("dbz_cleared", div_by_zero, 0);

    // Start while busy is ignored; exactly one done follows.
    run_div(4'd14, 4'd4, 2, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("no_extra_done", done, 0);
      check("no_extra_busy", busy, 0);
    end
    check("busy_result_q", quotient, 3);
    check("busy_result_r", remainder, 2);

    // Reset during the third calculation cycle abandons the division.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_q", quotient, 0);
    check("mid_rst_r", remainder, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    rst_n  = 1'b1;
    prev_q = 4'd0;
    prev_r = 4'd0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_done", done, 0);
      check("mid_rst_idle", busy, 0);
    end
    run_div(4'd11, 4'd2, 0, 1'b1);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      pair = i[7:0];
      run_div(pair[7:4], pair[3:0], 0, pair[3:0] != 4'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Unsigned 4-bit sequential restoring divider that computes quotient and remainder over several clock cycles. Each iteration is one trial subtraction (A + ~B + 1), which is how the lab's 4-bit add/subtract datapath computes subtraction. The block sits beside the adder/subtractor in the Lab1 arithmetic unit. A start/done handshake lets a controller or testbench issue one division at a time.

## Interface
- No parameters; the width is fixed at 4 bits.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- start  input  1  request pulse; accepted only when busy=0.
- dividend  input  4  unsigned dividend; sampled on the edge that accepts start.
- divisor  input  4  unsigned divisor; sampled on the edge that accepts start.
- busy  output  1  high while a division is in progress; start is ignored while high.
- done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid in this cycle.
- quotient  output  4  unsigned quotient; holds until the next accepted start.
- remainder  output  4  unsigned remainder; holds until the next accepted start.
- div_by_zero  output  1  set when the accepted divisor was 0; holds until the next accepted start.

## Operation
- Internal registers:
  - a_reg[3:0]: dividend shifting out, with quotient bits shifting in.
  - r_reg[4:0]: partial remainder.
  - d_reg[3:0]: latched divisor.
  - cnt[1:0]: iteration count.
- States: IDLE, CALC, FIN.
- IDLE:
  - busy=0.
  - On start=1 with divisor≠0: a_reg←dividend, d_reg←divisor, r_reg←0, cnt←0, go to CALC.
  - On start=1 with divisor=0: go directly to FIN with quotient←4'hF, remainder←dividend, div_by_zero←1.
- Starting a new division clears div_by_zero to 0.
- CALC iteration, one per cycle:
  - Form shifted = {r_reg[3:0], a_reg[3]}.
  - Form trial = shifted − {1'b0, d_reg}, computed as shifted + ~{1'b0,d_reg} + 1 in 5 bits.
  - If trial[4]=0: r_reg←trial and a_reg←{a_reg[2:0],1}.
  - Otherwise: r_reg←shifted and a_reg←{a_reg[2:0],0}.
  - cnt←cnt+1.
- On the iteration with cnt=3: quotient←the new a_reg value, remainder←the new r_reg[3:0], go to FIN.
- FIN:
  - done=1 and busy=1 for exactly one cycle, then go to IDLE.
- start is ignored in CALC and FIN; there is no queueing.
- A start arriving in the same cycle that the FIN→IDLE transition takes effect is accepted on the next edge, while the state is IDLE.
- Arithmetic rules:
  - The remainder is always less than the divisor.
  - For divisor≠0, quotient × divisor + remainder = dividend.
  - The remainder never exceeds 4 bits; bit 4 of r_reg is always 0 after an iteration.
- Outputs are not updated during CALC. Previous results stay visible until FIN loads the new ones.

## Timing
- Reset (rst_n=0 at an edge):
  - State←IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - All internal registers←0.
- Reset overrides every other input in any state. A reset during CALC abandons the division, and done is not asserted for it.
- Timing, counting the start-accepting edge as edge 0:
  - busy is high from edge 0.
  - For divisor≠0: CALC edges are 1–4; done is high in the cycle after edge 4, and the FIN→IDLE transition takes effect at edge 5.
  - Latency for divisor≠0: 5 cycles from the start-accepting edge to done.
  - For divisor=0: done is high in the cycle after edge 0; latency is 1 cycle.
- Outputs are registered; there is no combinational path from the inputs to any output.
- Back-to-back throughput: one division per 6 cycles (start accepted at edge 6 at the earliest).

## Test plan
- Reset, then 13÷3: start with dividend=4'd13 and divisor=4'd3.
  - Expect exactly 5 cycles to done.
  - Expect quotient=4, remainder=1, div_by_zero=0.
  - Expect busy high for cycles 0–5.
- Boundary values:
  - 15÷1 → quotient=15, remainder=0.
  - 0÷7 → quotient=0, remainder=0.
  - 5÷9 → quotient=0, remainder=5.
  - 15÷15 → quotient=1, remainder=0.
- Divide by zero: 9÷0 → done one cycle after start, quotient=4'hF, remainder=9, div_by_zero=1. A following 8÷2 then clears div_by_zero and returns quotient=4, remainder=0.
- Start while busy: pulse start with 6÷2 at cycle 2 of a 14÷4 run.
  - Expect the 6÷2 request ignored.
  - Expect the result quotient=3, remainder=2, and only one done pulse.
- Reset mid-operation: drop rst_n during CALC cycle 3.
  - Expect all outputs 0 on the next edge, no done pulse, and state IDLE.
  - A subsequent 11÷2 gives quotient=5, remainder=1.
- Exhaustive: all 256 dividend/divisor pairs issued back-to-back. Check quotient and remainder against the / and % operators (divisor≠0), check the 5-cycle latency, and check results hold stable between done pulses.
